// File: rtl/core_ctrl.sv
// Tile sequencer: weight load, kernel load, activation stream/execute, OFIFO drain to pmem.
// Latency: inst/busy/done/err are registered, so a decision made at an edge shows up in the following cycle.
// Backpressure: DRAIN waits on ofifo_valid indefinitely; start is ignored while busy.
module core_ctrl #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int addr_bw  = 11,
    parameter int l0_depth = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic [6:0]         num_vec,
    input  logic               ofifo_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WXFER,
        S_KLOAD,
        S_KWAIT,
        S_XXFER,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int CW = 8;
    localparam logic [33:0]   IDLE_WORD  = 34'h1_800C_0000;
    localparam logic [CW-1:0] ROW_LAST   = CW'(row);
    localparam logic [CW-1:0] KLOAD_LAST = CW'(row - 1);
    localparam logic [CW-1:0] KWAIT_LAST = CW'(col - 1);
    localparam logic [6:0]    VEC_MAX    = 7'(l0_depth);

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [6:0]         n_q;
    logic [6:0]         rd_cnt, rd_cnt_n;
    logic [6:0]         wr_cnt, wr_cnt_n;
    logic [addr_bw-1:0] w_q, x_q, p_q;
    logic [addr_bw-1:0] w_src;
    logic [33:0]        inst_n;
    logic               accept, reject;

    assign accept = (state == S_IDLE) && start && (num_vec <= VEC_MAX);
    assign reject = (state == S_IDLE) && start && (num_vec > VEC_MAX);

    always_comb begin : next_state
        state_n = state;
        cnt_n   = cnt + CW'(1);
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (accept) state_n = S_WXFER;
            end
            S_WXFER: begin
                if (cnt == ROW_LAST) begin
                    state_n = S_KLOAD;
                    cnt_n   = '0;
                end
            end
            S_KLOAD: begin
                if (cnt == KLOAD_LAST) begin
                    state_n = S_KWAIT;
                    cnt_n   = '0;
                end
            end
            S_KWAIT: begin
                if (cnt == KWAIT_LAST) begin
                    state_n = (n_q == 7'd0) ? S_DONE : S_XXFER;
                    cnt_n   = '0;
                end
            end
            S_XXFER: begin
                if (cnt == {1'b0, n_q}) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end
            end
            S_EXEC: begin
                if (cnt == {1'b0, n_q} - CW'(1)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end
            end
            S_DRAIN: begin
                cnt_n = cnt;
                if (wr_cnt == n_q) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // The word is built for the cycle being entered, so it is keyed on state_n/cnt_n.
    always_comb begin : next_inst
        inst_n   = IDLE_WORD;
        rd_cnt_n = '0;
        wr_cnt_n = '0;
        // On the accepting edge the weight base has not been latched yet.
        w_src    = (state == S_IDLE) ? w_base : w_q;
        case (state_n)
            S_WXFER: begin
                if (cnt_n < ROW_LAST) begin
                    inst_n[19]   = 1'b0;
                    inst_n[17:7] = 11'(w_src + addr_bw'(cnt_n));
                end
                inst_n[2] = (cnt_n != '0);
            end
            S_KLOAD: begin
                inst_n[0] = 1'b1;
                inst_n[3] = 1'b1;
            end
            S_XXFER: begin
                if (cnt_n < {1'b0, n_q}) begin
                    inst_n[19]   = 1'b0;
                    inst_n[17:7] = 11'(x_q + addr_bw'(cnt_n));
                end
                inst_n[2] = (cnt_n != '0);
            end
            S_EXEC: begin
                inst_n[1] = 1'b1;
                inst_n[3] = 1'b1;
            end
            S_DRAIN: begin
                rd_cnt_n = rd_cnt;
                wr_cnt_n = wr_cnt;
                if ((state == S_DRAIN) && ofifo_valid && (rd_cnt < n_q)) begin
                    inst_n[6] = 1'b1;
                    rd_cnt_n  = rd_cnt + 7'd1;
                end
                // The row popped last cycle is now on the OFIFO output; write it out.
                if (inst[6]) begin
                    inst_n[32]    = 1'b0;
                    inst_n[31]    = 1'b0;
                    inst_n[30:20] = 11'(p_q + addr_bw'(wr_cnt));
                    wr_cnt_n      = wr_cnt + 7'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            n_q    <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            w_q    <= '0;
            x_q    <= '0;
            p_q    <= '0;
            inst   <= IDLE_WORD;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rd_cnt <= rd_cnt_n;
            wr_cnt <= wr_cnt_n;
            inst   <= inst_n;
            busy   <= (state_n != S_IDLE);
            done   <= (state_n == S_DONE);
            err    <= reject;
            if (accept) begin
                w_q <= w_base;
                x_q <= x_base;
                p_q <= p_base;
                n_q <= num_vec;
            end
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: per-cycle comparison of inst/busy/done/err against a phase-timeline model.
module tb_core_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [10:0] w_base, x_base, p_base;
    logic [6:0]  num_vec;
    logic [33:0] inst;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int vpat[6]  = '{1, 0, 0, 1, 0, 1};
    int dk;

    always #5 clk = ~clk;

    core_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .w_base     (w_base),
        .x_base     (x_base),
        .p_base     (p_base),
        .num_vec    (num_vec),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_inst"}, inst, IDLE_W);
        chk({tag, "_busy"}, {33'b0, busy}, 34'd0);
        chk({tag, "_done"}, {33'b0, done}, 34'd0);
    endtask

    // Expected instruction word from its field meanings; addresses wrap at 2^11.
    function automatic logic [33:0] mk(bit xr, int xa, bit l0w, bit l0r, bit ex, bit kl,
                                       bit ofr, bit pw, int pa);
        logic [33:0] wd;
        int xm, pm;
        wd = IDLE_W;
        xm = xa % 2048;
        pm = pa % 2048;
        if (xr) begin
            wd[19]   = 1'b0;
            wd[17:7] = xm[10:0];
        end
        if (pw) begin
            wd[32]    = 1'b0;
            wd[31]    = 1'b0;
            wd[30:20] = pm[10:0];
        end
        wd[6] = ofr;
        wd[3] = l0r;
        wd[2] = l0w;
        wd[1] = ex;
        wd[0] = kl;
        return wd;
    endfunction

    // Runs one tile from a negedge in IDLE; returns at the negedge of the first IDLE cycle
    // after DONE (or after cycle abort_k). vmode: 0 valid high, 1 fixed toggle, 2 random.
    task automatic run_tile(input int w, input int x, input int p, input int n, input int vmode,
                            input bit hold, input int abort_k, output int done_k);
        int t_kl, t_kw, t_x, t_e, t_d, done_at, nrd, nwr, off;
        bit prev_v, prev_rd, rd, wr, v, exp_busy;
        logic [33:0] e;
        w_base  = 11'(w);
        x_base  = 11'(x);
        p_base  = 11'(p);
        num_vec = 7'(n);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = hold;
        w_base  = 11'($urandom);
        x_base  = 11'($urandom);
        p_base  = 11'($urandom);
        num_vec = 7'($urandom);
        t_kl    = ROW + 1;
        t_kw    = 2 * ROW + 1;
        t_x     = t_kw + COL;
        t_e     = t_x + n + 1;
        t_d     = t_e + n;
        done_at = (n == 0) ? t_x : -1;
        nrd = 0;
        nwr = 0;
        prev_v  = 1'b0;
        prev_rd = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            rd = 1'b0;
            wr = 1'b0;
            e  = IDLE_W;
            if (k < t_kl) begin
                off = k;
                e = mk(off < ROW, w + off, off >= 1, 0, 0, 0, 0, 0, 0);
            end else if (k < t_kw) begin
                e = mk(0, 0, 0, 1, 0, 1, 0, 0, 0);
            end else if (k < t_x) begin
                e = IDLE_W;
            end else if (n > 0 && k < t_e) begin
                off = k - t_x;
                e = mk(off < n, x + off, off >= 1, 0, 0, 0, 0, 0, 0);
            end else if (n > 0 && k < t_d) begin
                e = mk(0, 0, 0, 1, 1, 0, 0, 0, 0);
            end else if (done_at < 0 || k < done_at) begin
                rd = (k > t_d) && prev_v && (nrd < n);
                wr = prev_rd;
                e = mk(0, 0, 0, 0, 0, 0, rd, wr, p + nwr);
                if (wr) begin
                    nwr++;
                    if (nwr == n) done_at = k + 1;
                end
                if (rd) nrd++;
            end
            exp_busy = (done_at < 0) || (k <= done_at);
            chk($sformatf("inst@%0d", k), inst, e);
            chk($sformatf("busy@%0d", k), {33'b0, busy}, {33'b0, exp_busy});
            chk($sformatf("done@%0d", k), {33'b0, done}, {33'b0, (k == done_at)});
            chk($sformatf("err@%0d", k), {33'b0, err}, 34'd0);
            if (k == abort_k || (done_at >= 0 && k == done_at + 1)) begin
                if (!hold) start = 1'b0;
                done_k = done_at;
                return;
            end
            if (k < t_d) v = 1'($urandom);
            else if (vmode == 0) v = 1'b1;
            else if (vmode == 1) v = (k - t_d < 6) ? 1'(vpat[k - t_d]) : 1'b0;
            else v = 1'($urandom);
            ofifo_valid = v;
            prev_v  = v;
            prev_rd = rd;
            // Random start pulses while busy, and always one on the DONE cycle.
            if (!hold) start = (k == done_at) ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
        chk("tile_done_timeout", {33'b0, done}, 34'd1);
        start  = 1'b0;
        done_k = -1;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        ofifo_valid = 1'b0;
        w_base      = '0;
        x_base      = '0;
        p_base      = '0;
        num_vec     = '0;
        repeat (2) @(negedge clk);
        idle_chk("reset");
        chk("reset_err", {33'b0, err}, 34'd0);
        reset = 1'b1;
        @(negedge clk);
        idle_chk("post_reset");

        // Nominal tile.
        run_tile(0, 16, 100, 4, 0, 0, -1, dk);
        chk("nominal_done_cycle", 34'(dk), 34'd40);

        // Backpressure with toggling valid.
        run_tile(300, 500, 700, 3, 1, 0, -1, dk);

        // Address wrap on pmem and xmem.
        run_tile(5, 20, 2046, 4, 2, 0, -1, dk);
        run_tile(100, 2047, 300, 4, 0, 0, -1, dk);

        // Empty tile goes straight from KWAIT to DONE.
        run_tile(2044, 7, 9, 0, 0, 0, -1, dk);
        chk("n0_done_cycle", 34'(dk), 34'(2 * ROW + 1 + COL));

        // Oversized requests are rejected with a one-cycle err.
        for (int i = 0; i < 2; i++) begin
            num_vec = (i == 0) ? 7'd65 : 7'd127;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("reject%0d_err", i), {33'b0, err}, 34'd1);
            idle_chk($sformatf("reject%0d", i));
            @(negedge clk);
            chk($sformatf("reject%0d_err_clear", i), {33'b0, err}, 34'd0);
            idle_chk($sformatf("reject%0d_after", i));
        end

        // Start held high: one tile, next accepted on the first IDLE cycle after DONE.
        run_tile(11, 22, 33, 2, 0, 1, -1, dk);
        run_tile(44, 55, 66, 3, 2, 0, -1, dk);

        // Boundary vector counts.
        run_tile(1, 2, 3, 64, 2, 0, -1, dk);
        run_tile(2047, 2047, 2047, 1, 2, 0, -1, dk);

        // Asynchronous reset in the middle of EXEC.
        run_tile(0, 16, 100, 4, 0, 0, 2 * ROW + 1 + COL + 5 + 2, dk);
        #1;
        reset = 1'b0;
        #1;
        idle_chk("midtile_reset");
        chk("midtile_reset_err", {33'b0, err}, 34'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_chk($sformatf("after_reset%0d", i));
        end

        // Random tiles.
        for (int i = 0; i < 6; i++) begin
            run_tile($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                     $urandom_range(0, 64), 2, 0, -1, dk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
